// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the single common data bus to one of three result
// producers (integer ALU=0, branch ALU=1, load unit=2) per cycle and
// registers the winner's tag/data/source for broadcast on the next cycle.
// Build option: define CDB_ARB_RR_EN for a rotating priority pointer;
// without it the arbiter uses fixed priority LD > ALU > BRA.
module cdb_arbiter #(
   parameter int unsigned      DATA_W = 32,
   parameter int unsigned      TAG_W  = 4,
   parameter logic [TAG_W-1:0] NO_TAG = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alu_req_valid,
   input  logic [TAG_W-1:0]  alu_req_tag,
   input  logic [DATA_W-1:0] alu_req_data,
   output logic              alu_req_ready,
   input  logic              bra_req_valid,
   input  logic [TAG_W-1:0]  bra_req_tag,
   input  logic [DATA_W-1:0] bra_req_data,
   output logic              bra_req_ready,
   input  logic              ld_req_valid,
   input  logic [TAG_W-1:0]  ld_req_tag,
   input  logic [DATA_W-1:0] ld_req_data,
   output logic              ld_req_ready,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_data,
   output logic [1:0]        cdb_src
);

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_BRA  = 2'd1;
   localparam logic [1:0] SRC_LD   = 2'd2;
   localparam logic [1:0] SRC_NONE = 2'd3;

   logic [2:0]        w_req;
   logic [1:0]        w_win;
   logic [TAG_W-1:0]  w_tag;
   logic [DATA_W-1:0] w_data;

   assign w_req = {ld_req_valid, bra_req_valid, alu_req_valid};

`ifdef CDB_ARB_RR_EN
   logic [1:0] r_ptr;
   logic [1:0] w_ptr_eff;

   // An out-of-range pointer is folded back to the ALU starting point
   assign w_ptr_eff = (r_ptr == 2'd3) ? 2'd0 : r_ptr;

   // Winner select: first valid requester searching from the pointer upward
   always_comb begin
      w_win = SRC_NONE;
      case (w_ptr_eff)
         2'd1: begin
            if      (w_req[1]) w_win = SRC_BRA;
            else if (w_req[2]) w_win = SRC_LD;
            else if (w_req[0]) w_win = SRC_ALU;
         end
         2'd2: begin
            if      (w_req[2]) w_win = SRC_LD;
            else if (w_req[0]) w_win = SRC_ALU;
            else if (w_req[1]) w_win = SRC_BRA;
         end
         default: begin
            if      (w_req[0]) w_win = SRC_ALU;
            else if (w_req[1]) w_win = SRC_BRA;
            else if (w_req[2]) w_win = SRC_LD;
         end
      endcase
      if (rst || flush) w_win = SRC_NONE;
   end

   // Pointer moves just past the last winner; idle and flushed cycles hold it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 2'd0;
      end else if (w_win != SRC_NONE) begin
         r_ptr <= (w_win == SRC_LD) ? 2'd0 : w_win + 2'd1;
      end
   end
`else
   // Winner select: fixed priority, load first, then ALU, then branch
   always_comb begin
      w_win = SRC_NONE;
      if      (w_req[2]) w_win = SRC_LD;
      else if (w_req[0]) w_win = SRC_ALU;
      else if (w_req[1]) w_win = SRC_BRA;
      if (rst || flush) w_win = SRC_NONE;
   end
`endif

   assign alu_req_ready = (w_win == SRC_ALU);
   assign bra_req_ready = (w_win == SRC_BRA);
   assign ld_req_ready  = (w_win == SRC_LD);

   // Payload mux for the granted producer; value is ignored when nobody wins
   always_comb begin
      case (w_win)
         SRC_ALU: begin
            w_tag  = alu_req_tag;
            w_data = alu_req_data;
         end
         SRC_BRA: begin
            w_tag  = bra_req_tag;
            w_data = bra_req_data;
         end
         default: begin
            w_tag  = ld_req_tag;
            w_data = ld_req_data;
         end
      endcase
   end

   // Broadcast register: capture the winner or drive the idle pattern
   always_ff @(posedge clk) begin
      if (rst || (w_win == SRC_NONE)) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= NO_TAG;
         cdb_data  <= '0;
         cdb_src   <= SRC_NONE;
      end else begin
         cdb_valid <= 1'b1;
         cdb_tag   <= w_tag;
         cdb_data  <= w_data;
         cdb_src   <= w_win;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a reference arbitration model predicts
// each cycle's grant; predicted broadcasts are queued and compared one cycle
// later against the CDB outputs. Works for both the round-robin and the
// fixed-priority build.
module tb_cdb_arbiter;

`ifdef CDB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic        valid;
      logic [3:0]  tag;
      logic [31:0] data;
      logic [1:0]  src;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        alu_req_valid, bra_req_valid, ld_req_valid;
   logic [3:0]  alu_req_tag, bra_req_tag, ld_req_tag;
   logic [31:0] alu_req_data, bra_req_data, ld_req_data;
   logic        alu_req_ready, bra_req_ready, ld_req_ready;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   exp_t        sb[$];
   int          n_total = 0;
   int          n_pass  = 0;
   logic [1:0]  m_ptr   = 2'd0;
   logic [1:0]  m_win   = 2'd3;
   logic [1:0]  prev_src;

   always #5 clk = ~clk;

   cdb_arbiter #(.DATA_W(32), .TAG_W(4), .NO_TAG(4'hF)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alu_req_valid(alu_req_valid), .alu_req_tag(alu_req_tag),
      .alu_req_data(alu_req_data), .alu_req_ready(alu_req_ready),
      .bra_req_valid(bra_req_valid), .bra_req_tag(bra_req_tag),
      .bra_req_data(bra_req_data), .bra_req_ready(bra_req_ready),
      .ld_req_valid(ld_req_valid), .ld_req_tag(ld_req_tag),
      .ld_req_data(ld_req_data), .ld_req_ready(ld_req_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_src(cdb_src)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Reference grant: 3 means no grant
   function automatic logic [1:0] model_win(input logic [2:0] v, input logic [1:0] p);
      logic [1:0] idx;
      if (RR) begin
         for (int k = 0; k < 3; k++) begin
            idx = 2'((int'((p == 2'd3) ? 2'd0 : p) + k) % 3);
            if (v[idx]) return idx;
         end
         return 2'd3;
      end else begin
         if (v[2]) return 2'd2;
         if (v[0]) return 2'd0;
         if (v[1]) return 2'd1;
         return 2'd3;
      end
   endfunction

   // One clock cycle: compare last prediction, predict this cycle, advance
   task automatic step();
      logic [1:0] w;
      exp_t       e, n;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("cdb_valid", cdb_valid, e.valid);
         check("cdb_tag",   cdb_tag,   e.tag);
         check("cdb_data",  cdb_data,  e.data);
         check("cdb_src",   cdb_src,   e.src);
      end
      w = (rst || flush) ? 2'd3 : model_win({ld_req_valid, bra_req_valid, alu_req_valid}, m_ptr);
      check("alu_ready", alu_req_ready, w == 2'd0);
      check("bra_ready", bra_req_ready, w == 2'd1);
      check("ld_ready",  ld_req_ready,  w == 2'd2);
      case (w)
         2'd0:    n = '{1'b1, alu_req_tag, alu_req_data, 2'd0};
         2'd1:    n = '{1'b1, bra_req_tag, bra_req_data, 2'd1};
         2'd2:    n = '{1'b1, ld_req_tag,  ld_req_data,  2'd2};
         default: n = '{1'b0, 4'hF, 32'h0, 2'd3};
      endcase
      sb.push_back(n);
      if (rst) m_ptr = 2'd0;
      else if (w != 2'd3) m_ptr = (w == 2'd2) ? 2'd0 : w + 2'd1;
      m_win = w;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_granted();
      if (m_win == 2'd0) alu_req_valid = 1'b0;
      if (m_win == 2'd1) bra_req_valid = 1'b0;
      if (m_win == 2'd2) ld_req_valid  = 1'b0;
   endtask

   initial begin
      logic [3:0] seq_exp [3];
      if (RR) seq_exp = '{4'h1, 4'h2, 4'h3};
      else    seq_exp = '{4'h3, 4'h1, 4'h2};

      // Reset held two cycles with all three producers requesting
      rst = 1'b1; flush = 1'b0;
      alu_req_valid = 1'b1; alu_req_tag = 4'h1; alu_req_data = 32'h0000_1111;
      bra_req_valid = 1'b1; bra_req_tag = 4'h2; bra_req_data = 32'h0000_2222;
      ld_req_valid  = 1'b1; ld_req_tag  = 4'h3; ld_req_data  = 32'h0000_3333;
      @(posedge clk); #1;
      sb.push_back('{1'b0, 4'hF, 32'h0, 2'd3});
      step();
      step();
      rst = 1'b0;
      #1;
      check("post_rst_alu_ready", alu_req_ready, RR);

      // All three held; each drops valid after its grant
      for (int i = 0; i < 3; i++) begin
         step();
         check("seq_tag", cdb_tag, seq_exp[i]);
         drop_granted();
      end

      // Single ALU request
      alu_req_valid = 1'b1; alu_req_tag = 4'h3; alu_req_data = 32'h0000_00AA;
      step();
      check("single_tag",  cdb_tag,  4'h3);
      check("single_data", cdb_data, 32'hAA);
      check("single_src",  cdb_src,  2'd0);
      drop_granted();
      step();
      check("single_idle_valid", cdb_valid, 1'b0);
      check("single_idle_tag",   cdb_tag,   4'hF);

      // ALU and LD continuously valid for 6 cycles
      alu_req_valid = 1'b1; ld_req_valid = 1'b1;
      alu_req_tag = 4'h8; ld_req_tag = 4'h9;
      prev_src = 2'd3;
      for (int i = 0; i < 6; i++) begin
         step();
         check("starve", RR ? (cdb_src != prev_src) : (cdb_src == 2'd2), 1'b1);
         prev_src = cdb_src;
      end
      alu_req_valid = 1'b0; ld_req_valid = 1'b0;
      step();

      // Flush kills a same-cycle load request
      ld_req_valid = 1'b1; ld_req_tag = 4'h5; ld_req_data = 32'h0000_0055; flush = 1'b1;
      #1;
      check("flush_ld_ready", ld_req_ready, 1'b0);
      step();
      check("flush_cdb_valid", cdb_valid, 1'b0);
      flush = 1'b0;
      step();
      check("post_flush_tag",   cdb_tag,   4'h5);
      check("post_flush_valid", cdb_valid, 1'b1);
      drop_granted();

      // Reset the cycle after a branch grant
      bra_req_valid = 1'b1; bra_req_tag = 4'h7; bra_req_data = 32'h0000_0077;
      step();
      drop_granted();
      rst = 1'b1; alu_req_valid = 1'b1; alu_req_tag = 4'hA; alu_req_data = 32'h0000_00A0;
      step();
      check("midrst_valid", cdb_valid, 1'b0);
      check("midrst_src",   cdb_src,   2'd3);
      rst = 1'b0;
      bra_req_valid = 1'b1; ld_req_valid = 1'b1;
      #1;
      check("midrst_ptr0", alu_req_ready, RR);
      for (int i = 0; i < 3; i++) begin
         step();
         drop_granted();
      end

      // Random traffic with held requests and occasional flushes
      for (int c = 0; c < 40; c++) begin
         flush = ($urandom_range(7) == 0);
         if (!alu_req_valid && $urandom_range(1) == 1) begin
            alu_req_valid = 1'b1; alu_req_tag = 4'($urandom); alu_req_data = $urandom;
         end
         if (!bra_req_valid && $urandom_range(1) == 1) begin
            bra_req_valid = 1'b1; bra_req_tag = 4'($urandom); bra_req_data = $urandom;
         end
         if (!ld_req_valid && $urandom_range(1) == 1) begin
            ld_req_valid = 1'b1; ld_req_tag = 4'($urandom); ld_req_data = $urandom;
         end
         step();
         drop_granted();
      end

      flush = 1'b0;
      alu_req_valid = 1'b0; bra_req_valid = 1'b0; ld_req_valid = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
